// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline and a word-wide data memory with a
// one-cycle registered read. Byte and halfword stores are done as
// read-modify-write; loads are lane-selected and sign/zero extended.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      LD_ISSUE,
      LD_WAIT,
      ST_WORD,
      RMW_ISSUE,
      RMW_WRITE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t      state_q, state_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        req_err;
   logic        accept;
   logic [31:0] merged;
   logic [31:0] load_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign accept = req_valid && req_ready;

   // The memory only ever sees word-aligned addresses from the captured request.
   assign mem_raddr = {addr_q[31:2], 2'b00};
   assign mem_waddr = {addr_q[31:2], 2'b00};

   // Classify the incoming request as misaligned or carrying an illegal width code.
   // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
   always_comb begin
      req_err = 1'b0;
      if (req_we) begin
         case (req_funct3)
            F3_B:    req_err = 1'b0;
            F3_H:    req_err = req_addr[0];
            F3_W:    req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            F3_B, F3_BU: req_err = 1'b0;
            F3_H, F3_HU: req_err = req_addr[0];
            F3_W:        req_err = (req_addr[1:0] != 2'b00);
            default:     req_err = 1'b1;
         endcase
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and memory-side strobes.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'h0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)                 state_d = IDLE;
               else if (!req_we)            state_d = LD_ISSUE;
               else if (req_funct3 == F3_W) state_d = ST_WORD;
               else                         state_d = RMW_ISSUE;
            end
         end
         LD_ISSUE:  state_d = LD_WAIT;
         LD_WAIT:   state_d = IDLE;
         ST_WORD: begin
            mem_we    = we_q;
            mem_wdata = wdata_q;
            state_d   = IDLE;
         end
         RMW_ISSUE: state_d = RMW_WRITE;
         RMW_WRITE: begin
            mem_we    = we_q;
            mem_wdata = merged;
            state_d   = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   // Capture the request on acceptance; inputs are ignored until back in IDLE.
   // NOTE: these are plain registers, so they are cleared on reset; the memory itself is external.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
      end else if (accept) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
      end
   end

   // Replace the addressed byte or halfword of the read word with store data.
   always_comb begin
      merged = mem_rdata;
      if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // Select the load lane and extend it according to the width code.
   always_comb begin
      ld_byte   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_data = 32'h0;
      case (funct3_q)
         F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
         F3_W:    load_data = mem_rdata;
         F3_BU:   load_data = {24'h0, ld_byte};
         F3_HU:   load_data = {16'h0, ld_half};
         default: load_data = 32'h0;
      endcase
   end

   // Single-cycle response pulse: errors after acceptance, loads after the
   // read returns, stores after their write edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_err) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            LD_WAIT: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= load_data;
            end
            ST_WORD, RMW_WRITE: rsp_valid <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural word memory with a
// one-cycle registered read, a table of requests with hand-computed results,
// and a hand-written reset-abort sequence.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_raddr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        preload = 1'b1;

   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_raddr  (mem_raddr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Data memory: registered read returns the old word, write on the edge.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4] <= 32'h8000_80F0;  // 0x10
         mem[8] <= 32'h1122_3344;  // 0x20
      end else if (mem_we) begin
         mem[mem_waddr[7:2]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_raddr[7:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_edges;   // posedges from acceptance up to the rsp_valid cycle
      logic [31:0] exp_waddr;
      logic [31:0] exp_wdata;
   } vec_t;

   // Called at a negedge; returns at the negedge where rsp_valid is seen, so
   // consecutive calls issue requests back-to-back.
   task automatic do_req(input vec_t v, input int idx);
      int edges;
      int nw;
      int we_edge;
      logic [31:0] wa;
      logic [31:0] wd;
      nw = 0; we_edge = 0; wa = 32'h0; wd = 32'h0;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      check($sformatf("v%0d ready", idx), {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      // Garbage on the request bus must not disturb the captured request.
      req_valid  = 1'b0;
      req_we     = ~v.we;
      req_funct3 = 3'b111;
      req_addr   = 32'h5555_5555;
      req_wdata  = 32'hA5A5_A5A5;
      edges = 1;
      forever begin
         if (mem_we) begin
            nw++;
            wa = mem_waddr;
            wd = mem_wdata;
            we_edge = edges;
         end
         if (rsp_valid || edges >= 10) break;
         @(negedge clk);
         edges++;
      end
      check($sformatf("v%0d latency", idx), edges, v.exp_edges);
      check($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d err", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
      check($sformatf("v%0d writes", idx), nw, (v.we && !v.exp_err) ? 1 : 0);
      if (v.we && !v.exp_err) begin
         check($sformatf("v%0d waddr", idx), wa, v.exp_waddr);
         check($sformatf("v%0d wdata", idx), wd, v.exp_wdata);
         check($sformatf("v%0d write edge", idx), we_edge, v.exp_edges - 1);
      end
   endtask

   vec_t vecs [20];
   int   nvec;

   initial begin
      nvec = 0;
      //                  we    f3      addr           wdata          rdata          err  edges waddr         wdata
      vecs[nvec++] = '{1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFF0, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,         32'h0000_00F0, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_8000, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_80F0, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h8000_80F0, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b1, 3'b000, 32'h0000_0021, 32'hFFFF_FFAB, 32'h0,         1'b0, 3, 32'h0000_0020, 32'h1122_AB44};
      vecs[nvec++] = '{1'b1, 3'b001, 32'h0000_0022, 32'h1234_BEEF, 32'h0,         1'b0, 3, 32'h0000_0020, 32'hBEEF_AB44};
      vecs[nvec++] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'hBEEF_AB44, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b1, 3'b010, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'h0000_0030, 32'hDEAD_BEEF};
      vecs[nvec++] = '{1'b0, 3'b010, 32'h0000_0030, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b101, 32'h0000_0032, 32'h0,         32'h0000_DEAD, 1'b0, 3, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b010, 32'h0000_0031, 32'h0,         32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b1, 3'b001, 32'h0000_0033, 32'h0000_1234, 32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b1, 3'b100, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b001, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 32'h0,         32'h0};
      vecs[nvec++] = '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_005A, 32'h0,         1'b0, 3, 32'hFFFF_FFFC, 32'h5A00_0000};
      vecs[nvec++] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,         32'h0000_005A, 1'b0, 3, 32'h0,         32'h0};

      // Reset state.
      #1 rst_n = 1'b0;
      #1;
      check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset mem_we", {31'h0, mem_we}, 32'h0);
      check("reset mem_waddr", mem_waddr, 32'h0);
      check("reset mem_raddr", mem_raddr, 32'h0);
      check("reset mem_wdata", mem_wdata, 32'h0);
      check("reset req_ready", {31'h0, req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      preload = 1'b0;
      @(negedge clk);

      for (int i = 0; i < nvec; i++) do_req(vecs[i], i);

      // Reset while in RMW_WRITE of SB @0x20: the write must be abandoned.
      @(negedge clk);
      check("pulse width", {31'h0, rsp_valid}, 32'h0);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h0000_0020;
      req_wdata  = 32'h0000_0077;
      check("abort ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("abort we before reset", {31'h0, mem_we}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("abort we dropped", {31'h0, mem_we}, 32'h0);
      check("abort no rsp", {31'h0, rsp_valid}, 32'h0);
      check("abort waddr", mem_waddr, 32'h0);
      check("abort wdata", mem_wdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort ready after release", {31'h0, req_ready}, 32'h1);
      check("abort no rsp after release", {31'h0, rsp_valid}, 32'h0);
      check("abort word unchanged", mem[8], 32'hBEEF_AB44);
      do_req('{1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hBEEF_AB44, 1'b0, 3, 32'h0, 32'h0}, 99);
      @(negedge clk);
      check("final pulse width", {31'h0, rsp_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
